ripple_count_monitor: RTL and testbench

- Downstream consumer of the JK-based asynchronous ripple counter.
- The counter's q bus is asynchronous to the system clock and glitches while bits ripple. This block does three things to it:
  - synchronises it into the clk domain;
  - rejects transient ripple values;
  - commits only settled counts, classifying each commit as a step, a wrap or an error.
- Provides a clean count, single-cycle event pulses and an error tally to the rest of the counter subsystem.

---
 rtl/ripple_mon_pkg.sv | 24 ++
 rtl/bus_stab_filter.sv | 53 +++++
 rtl/ripple_count_monitor.sv | 134 +++++++++++++
 tb/tb_ripple_count_monitor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ripple_mon_pkg.sv
// Shared types and helpers for the ripple counter monitor.
// Holds the FSM state type, the fixed widths and the mod-2^W next-count helper.
`timescale 1ns/1ps
package ripple_mon_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int ERR_CNT_W   = 8;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } mon_state_e;

    // Count expected after one step in the given direction, wrapped to w bits.
    function automatic logic [31:0] expected_next(input logic [31:0] cur,
                                                  input logic        down,
                                                  input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return down ? ((cur - 32'd1) & mask) : ((cur + 32'd1) & mask);
    endfunction

endpackage

// File: rtl/bus_stab_filter.sv
// Brings an asynchronous, glitching bus into the clk domain and flags when the
// synchronised value has been identical for STABLE_CYCLES consecutive samples.
`timescale 1ns/1ps
module bus_stab_filter
    import ripple_mon_pkg::*;
#(
    parameter int W             = 3,
    parameter int STABLE_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] bus_i,
    output logic [W-1:0] cand_o,
    output logic         settled_o
);

    localparam int            STAB_W   = 4;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

    logic [W-1:0]      sync_q [SYNC_STAGES];
    logic [W-1:0]      s2;
    logic [W-1:0]      cand_q;
    logic [STAB_W-1:0] stab_q;

    assign s2 = sync_q[SYNC_STAGES-1];

    // No per-bit handshake: skewed bits look like short-lived values and are
    // rejected by the stability counter below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            cand_q <= '0;
            stab_q <= '0;
        end else begin
            sync_q[0] <= bus_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            if (s2 != cand_q) begin
                cand_q <= s2;
                stab_q <= '0;
            end else if (stab_q != STAB_MAX) begin
                stab_q <= stab_q + 1'b1;
            end
        end
    end

    assign cand_o    = cand_q;
    assign settled_o = (s2 == cand_q) && (stab_q == STAB_MAX);

endmodule

// File: rtl/ripple_count_monitor.sv
// Commits settled ripple-counter values into the clk domain and classifies
// each commit as a step, a wrapping step or an error.
`timescale 1ns/1ps
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int W             = 3,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         cnt_in,
    input  logic                 mode_down,
    input  logic                 clear,
    output logic [W-1:0]         cnt_out,
    output logic                 cnt_valid,
    output logic                 step_pulse,
    output logic                 wrap_pulse,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [W-1:0] cand;
    logic         settled;

    bus_stab_filter #(
        .W             (W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .bus_i     (cnt_in),
        .cand_o    (cand),
        .settled_o (settled)
    );

    mon_state_e           state_q,   state_d;
    logic [1:0]           sync_cnt_q, sync_cnt_d;
    logic [W-1:0]         cnt_q,     cnt_d;
    logic                 valid_q,   valid_d;
    logic                 step_q,    step_d;
    logic                 wrap_q,    wrap_d;
    logic                 err_q,     err_d;
    logic [ERR_CNT_W-1:0] errcnt_q,  errcnt_d;
    logic                 is_step;
    logic                 at_wrap_edge;

    assign is_step      = (32'(cand) == expected_next(32'(cnt_q), mode_down, W));
    assign at_wrap_edge = mode_down ? (cnt_q == '0) : (cnt_q == {W{1'b1}});

    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        step_d     = 1'b0;
        wrap_d     = 1'b0;
        err_d      = 1'b0;
        errcnt_d   = errcnt_q;

        case (state_q)
            SYNC: begin
                if (sync_cnt_q == 2'(SYNC_STAGES - 1)) begin
                    state_d = ACQUIRE;
                end else begin
                    sync_cnt_d = sync_cnt_q + 1'b1;
                end
            end
            ACQUIRE: begin
                if (settled) begin
                    cnt_d   = cand;
                    valid_d = 1'b1;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (settled && (cand != cnt_q)) begin
                    cnt_d = cand;
                    if (is_step) begin
                        step_d = 1'b1;
                        wrap_d = at_wrap_edge;
                    end else begin
                        err_d = 1'b1;
                        if (errcnt_q != '1) begin
                            errcnt_d = errcnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = SYNC;
        endcase

        // Re-acquire wins over any commit landing in the same cycle.
        if (clear) begin
            state_d  = ACQUIRE;
            cnt_d    = cnt_q;
            valid_d  = 1'b0;
            errcnt_d = '0;
            step_d   = 1'b0;
            wrap_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SYNC;
            sync_cnt_q <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            errcnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            errcnt_q   <= errcnt_d;
        end
    end

    assign cnt_out    = cnt_q;
    assign cnt_valid  = valid_q;
    assign step_pulse = step_q;
    assign wrap_pulse = wrap_q;
    assign err_pulse  = err_q;
    assign err_count  = errcnt_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Randomised and directed bench for ripple_count_monitor against a
// segment-level reference model of committed counts, pulses and error tally.
`timescale 1ns/1ps
module tb_ripple_count_monitor;

    localparam int W    = 3;
    localparam int SC   = 3;
    localparam int MAXV = (1 << W) - 1;
    localparam int HOLD = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] cnt_in;
    logic         mode_down;
    logic         clear;
    logic [W-1:0] cnt_out;
    logic         cnt_valid;
    logic         step_pulse;
    logic         wrap_pulse;
    logic         err_pulse;
    logic [7:0]   err_count;

    int n_vec = 0;
    int n_bad = 0;

    // pulse tallies, sampled once per cycle
    int steps_seen = 0;
    int wraps_seen = 0;
    int errs_seen  = 0;

    // reference model state
    int m_cnt;
    bit m_valid;
    int m_err;
    int m_steps, m_wraps, m_errs;

    always #5 clk = ~clk;

    ripple_count_monitor #(.W(W), .STABLE_CYCLES(SC)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .mode_down  (mode_down),
        .clear      (clear),
        .cnt_out    (cnt_out),
        .cnt_valid  (cnt_valid),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    always @(negedge clk) begin
        if (step_pulse === 1'b1) steps_seen <= steps_seen + 1;
        if (wrap_pulse === 1'b1) wraps_seen <= wraps_seen + 1;
        if (err_pulse  === 1'b1) errs_seen  <= errs_seen + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Apply the commit rules to a value that has been held long enough to settle.
    task automatic model_commit(input int v);
        int nxt;
        if (!m_valid) begin
            m_cnt   = v;
            m_valid = 1'b1;
        end else if (v != m_cnt) begin
            nxt = mode_down ? (m_cnt + MAXV) % (MAXV + 1) : (m_cnt + 1) % (MAXV + 1);
            if (v == nxt) begin
                m_steps++;
                if (mode_down ? (m_cnt == 0) : (m_cnt == MAXV)) m_wraps++;
            end else begin
                m_errs++;
                if (m_err < 255) m_err++;
            end
            m_cnt = v;
        end
    endtask

    // nglitch single-cycle random values, then v held long enough to commit.
    task automatic segment(input int v, input int nglitch, input string tag);
        int s0, w0, e0;
        s0 = steps_seen; w0 = wraps_seen; e0 = errs_seen;
        m_steps = 0; m_wraps = 0; m_errs = 0;
        for (int g = 0; g < nglitch; g++) begin
            cnt_in = W'($urandom_range(0, MAXV));
            tick();
        end
        cnt_in = W'(v);
        repeat (HOLD) tick();
        model_commit(v);
        chk({tag, " cnt_out"},   int'(cnt_out),   m_cnt);
        chk({tag, " cnt_valid"}, int'(cnt_valid), int'(m_valid));
        chk({tag, " err_count"}, int'(err_count), m_err);
        chk({tag, " steps"},     steps_seen - s0, m_steps);
        chk({tag, " wraps"},     wraps_seen - w0, m_wraps);
        chk({tag, " errs"},      errs_seen - e0,  m_errs);
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (cnt_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, v, s0, w0, e0;

        // reset and first acquisition
        rst = 1'b1; cnt_in = '0; mode_down = 1'b1; clear = 1'b0;
        #12;
        chk("rst cnt_out",   int'(cnt_out),   0);
        chk("rst cnt_valid", int'(cnt_valid), 0);
        chk("rst err_count", int'(err_count), 0);
        chk("rst pulses",    int'({step_pulse, wrap_pulse, err_pulse}), 0);
        #10;
        rst = 1'b0;
        s0 = steps_seen; w0 = wraps_seen; e0 = errs_seen;
        wait_valid(20, lat);
        chk("acq latency window", int'(lat >= 3 && lat <= 10), 1);
        chk("acq cnt_out", int'(cnt_out), 0);
        repeat (4) tick();
        chk("acq no pulses", (steps_seen - s0) + (wraps_seen - w0) + (errs_seen - e0), 0);
        m_cnt = 0; m_valid = 1'b1; m_err = 0;

        // down count with wrap, then a ripple glitch before 101
        segment(7, 0, "down 000->111");
        segment(6, 0, "down 111->110");
        cnt_in = 3'b100;
        tick();
        segment(5, 0, "glitch 100 then 101");

        // direction error, then error-tally saturation
        segment(7, 0, "dir err 101->111");
        for (int i = 0; i < 300; i++) begin
            segment((i % 2 == 0) ? 5 : 7, 0, "sat");
        end
        chk("sat err_count", int'(err_count), 255);

        // clear held across the cycle a new value commits
        v = (m_cnt + 3) % (MAXV + 1);
        s0 = steps_seen; w0 = wraps_seen; e0 = errs_seen;
        cnt_in = W'(v);
        tick(); tick();
        clear = 1'b1;
        repeat (8) tick();
        chk("clear cnt_valid", int'(cnt_valid), 0);
        chk("clear err_count", int'(err_count), 0);
        chk("clear no pulses", (steps_seen - s0) + (wraps_seen - w0) + (errs_seen - e0), 0);
        clear = 1'b0;
        wait_valid(20, lat);
        chk("clear reacq seen", int'(lat > 0), 1);
        chk("clear reacq cnt_out", int'(cnt_out), v);
        m_cnt = v; m_valid = 1'b1; m_err = 0;

        // randomised segments with glitches and direction changes
        for (int i = 0; i < 40; i++) begin
            mode_down = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                v = mode_down ? (m_cnt + MAXV) % (MAXV + 1) : (m_cnt + 1) % (MAXV + 1);
            end else begin
                v = $urandom_range(0, MAXV);
            end
            segment(v, $urandom_range(0, 2), "rand");
        end

        // reset between clock edges while tracking
        segment(2, 0, "pre-rst err");
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst cnt_out",   int'(cnt_out),   0);
        chk("midrst cnt_valid", int'(cnt_valid), 0);
        chk("midrst err_count", int'(err_count), 0);
        chk("midrst pulses",    int'({step_pulse, wrap_pulse, err_pulse}), 0);
        tick(); tick();
        cnt_in = 3'b110;
        rst = 1'b0;
        wait_valid(20, lat);
        chk("midrst reacq seen", int'(lat > 0), 1);
        repeat (HOLD) tick();
        chk("midrst reacq cnt_out", int'(cnt_out), 6);
        m_cnt = 6; m_valid = 1'b1; m_err = 0;
        mode_down = 1'b0;
        segment(7, 0, "up 110->111");
        segment(0, 1, "up wrap 111->000");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
